ins_checker: RTL and testbench

INS_CHECKER -- requirements
Module: ins_checker

---
 rtl/ins_checker_pkg.sv | 69 ++++++
 rtl/ins_checker_pc_sel_mux.sv | 18 +
 rtl/ins_checker.sv | 156 +++++++++++++++
 tb/tb_ins_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ins_checker_pkg.sv
// ins_checker_pkg
// Shared definitions for the instruction checker: opcode constants, the
// 3-bit instruction class, the control FSM states, the NOP encoding and
// the layout of the 19-bit communication word.
package ins_checker_pkg;

    // Opcode constants (ins[31:26])
    localparam logic [5:0] OP_ALU_R      = 6'h00;
    localparam logic [5:0] OP_ALU_IMM_LO = 6'h08;
    localparam logic [5:0] OP_ALU_IMM_HI = 6'h0F;
    localparam logic [5:0] OP_LOAD       = 6'h23;
    localparam logic [5:0] OP_STORE      = 6'h2B;
    localparam logic [5:0] OP_BEQ        = 6'h04;
    localparam logic [5:0] OP_BNE        = 6'h05;
    localparam logic [5:0] OP_J          = 6'h02;
    localparam logic [5:0] OP_JAL        = 6'h03;
    localparam logic [5:0] OP_HALT       = 6'h3F;

    // Bubble instruction
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'b000,
        CLS_LOAD    = 3'b001,
        CLS_STORE   = 3'b010,
        CLS_BRANCH  = 3'b011,
        CLS_JUMP    = 3'b100,
        CLS_HALT    = 3'b101,
        CLS_ILLEGAL = 3'b111
    } ins_class_t;

    typedef enum logic [2:0] {
        ST_START    = 3'd0,
        ST_RUN      = 3'd1,
        ST_STALL    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_HALTED   = 3'd4
    } state_t;

    // Communication word: {class, opcode, rs, rt}
    typedef struct packed {
        ins_class_t cls;
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
    } signal_t;

    localparam int SIGNAL_W = $bits(signal_t);

    function automatic ins_class_t classify(input logic [5:0] opcode);
        ins_class_t cls;
        cls = CLS_ILLEGAL;
        if (opcode == OP_ALU_R ||
            (opcode >= OP_ALU_IMM_LO && opcode <= OP_ALU_IMM_HI))
            cls = CLS_ALU;
        else if (opcode == OP_LOAD)
            cls = CLS_LOAD;
        else if (opcode == OP_STORE)
            cls = CLS_STORE;
        else if (opcode == OP_BEQ || opcode == OP_BNE)
            cls = CLS_BRANCH;
        else if (opcode == OP_J || opcode == OP_JAL)
            cls = CLS_JUMP;
        else if (opcode == OP_HALT)
            cls = CLS_HALT;
        return cls;
    endfunction

endpackage

// File: rtl/ins_checker_pc_sel_mux.sv
// pc_sel_mux
// Parameterised 2:1 multiplexer used to pick the next PC.
//   in_0   : selected when signal = 0
//   in_1   : selected when signal = 1
//   signal : select
//   out    : selected value (combinational)
module pc_sel_mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             signal,
    output logic [WIDTH-1:0] out
);

    assign out = signal ? in_1 : in_0;

endmodule

// File: rtl/ins_checker.sv
// ins_checker
// Issues fetched instructions to the control unit, inserting bubbles for
// illegal opcodes and for control hazards (BRANCH/JUMP stall PHASES-1
// cycles, then one redirect cycle that selects pc_in_1), and stopping
// permanently after HALT.
//
// Ports:
//   clock, reset             : clock, asynchronous active-high reset
//   ins_in                   : fetched instruction
//   wait_for_next_in         : freeze; while high nothing changes
//   pc_in_0 / pc_in_1        : sequential PC / redirect-or-start PC
//   pc_out                   : selected next PC (combinational)
//   ins_out                  : issued instruction (registered, 0 = bubble)
//   signal_out               : {class, opcode, rs, rt} (registered)
//   pc_choice_out            : PC select, 1 while in START or REDIRECT
//   cu_enable_out            : issued instruction valid
//   communication_enable_out : signal_out valid for LOAD/STORE/BRANCH/JUMP
//
// Handshake: the block has no backpressure of its own. An instruction on
// ins_in is consumed at a rising edge only when the FSM is in RUN and
// wait_for_next_in is low; cu_enable_out / communication_enable_out are
// single-cycle valid strobes that hold their value while frozen.
module ins_checker
    import ins_checker_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int PHASES    = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] ins_in,
    input  logic                 wait_for_next_in,
    input  logic [BUS_WIDTH-1:0] pc_in_0,
    input  logic [BUS_WIDTH-1:0] pc_in_1,
    output logic [BUS_WIDTH-1:0] pc_out,
    output logic [BUS_WIDTH-1:0] ins_out,
    output logic [SIGNAL_W-1:0]  signal_out,
    output logic                 pc_choice_out,
    output logic                 cu_enable_out,
    output logic                 communication_enable_out
);

    localparam int CNT_W = $clog2(PHASES) + 1;
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(PHASES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic [BUS_WIDTH-1:0] ins_n;
    signal_t              sig_n;
    logic                 pc_choice_n;
    logic                 cu_n;
    logic                 comm_n;

    signal_t    dec_sig;
    ins_class_t dec_cls;

    assign dec_cls = classify(ins_in[31:26]);
    assign dec_sig = '{cls: dec_cls, opcode: ins_in[31:26],
                       rs: ins_in[25:21], rt: ins_in[20:16]};

    pc_sel_mux #(.WIDTH(BUS_WIDTH)) u_pc_sel (
        .in_0   (pc_in_0),
        .in_1   (pc_in_1),
        .signal (pc_choice_out),
        .out    (pc_out)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_START;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!wait_for_next_in) begin
            case (state)
                ST_START: state_n = ST_RUN;
                ST_RUN: begin
                    case (dec_cls)
                        CLS_BRANCH, CLS_JUMP: begin
                            // With PHASES=1 there is nothing to count down.
                            if (STALL_LOAD == '0) begin
                                state_n = ST_REDIRECT;
                            end else begin
                                state_n = ST_STALL;
                                cnt_n   = STALL_LOAD;
                            end
                        end
                        CLS_HALT: state_n = ST_HALTED;
                        default:  state_n = ST_RUN;
                    endcase
                end
                ST_STALL: begin
                    cnt_n = (cnt == '0) ? '0 : cnt - 1'b1;
                    if (cnt <= CNT_W'(1))
                        state_n = ST_REDIRECT;
                end
                ST_REDIRECT: state_n = ST_RUN;
                ST_HALTED:   state_n = ST_HALTED;
                default:     state_n = ST_START;
            endcase
        end
    end

    // Output logic: next values of the registered outputs. pc_choice_out
    // is registered from the next state so it is high during the START
    // and REDIRECT cycles themselves.
    always_comb begin
        ins_n       = BUS_WIDTH'(NOP);
        sig_n       = signal_t'(signal_out);
        cu_n        = 1'b0;
        comm_n      = 1'b0;
        pc_choice_n = (state_n == ST_START) || (state_n == ST_REDIRECT);
        if (wait_for_next_in) begin
            ins_n       = ins_out;
            cu_n        = cu_enable_out;
            comm_n      = communication_enable_out;
            pc_choice_n = pc_choice_out;
        end else if (state == ST_RUN) begin
            sig_n = dec_sig;
            if (dec_cls != CLS_ILLEGAL) begin
                ins_n  = ins_in;
                cu_n   = 1'b1;
                comm_n = (dec_cls == CLS_LOAD)   || (dec_cls == CLS_STORE) ||
                         (dec_cls == CLS_BRANCH) || (dec_cls == CLS_JUMP);
            end
        end
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ins_out                  <= '0;
            signal_out               <= '0;
            pc_choice_out            <= 1'b1;
            cu_enable_out            <= 1'b0;
            communication_enable_out <= 1'b0;
        end else begin
            ins_out                  <= ins_n;
            signal_out               <= sig_n;
            pc_choice_out            <= pc_choice_n;
            cu_enable_out            <= cu_n;
            communication_enable_out <= comm_n;
        end
    end

endmodule

// File: tb/tb_ins_checker.sv
module tb_ins_checker;

    localparam int BW = 32;

    logic          clock;
    logic          reset;
    logic [BW-1:0] ins_in;
    logic          wait_for_next_in;
    logic [BW-1:0] pc_in_0;
    logic [BW-1:0] pc_in_1;
    logic [BW-1:0] pc_out;
    logic [BW-1:0] ins_out;
    logic [18:0]   signal_out;
    logic          pc_choice_out;
    logic          cu_enable_out;
    logic          communication_enable_out;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ALU    = 32'h0022_1000;
    localparam logic [31:0] I_LOAD   = 32'h8C43_0004;
    localparam logic [31:0] I_BRANCH = 32'h1085_0008;
    localparam logic [31:0] I_JUMP   = 32'h0800_0010;
    localparam logic [31:0] I_HALT   = 32'hFC00_0000;
    localparam logic [31:0] I_ADDI   = 32'h2022_0005;

    ins_checker #(.BUS_WIDTH(BW), .PHASES(5)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .ins_in                   (ins_in),
        .wait_for_next_in         (wait_for_next_in),
        .pc_in_0                  (pc_in_0),
        .pc_in_1                  (pc_in_1),
        .pc_out                   (pc_out),
        .ins_out                  (ins_out),
        .signal_out               (signal_out),
        .pc_choice_out            (pc_choice_out),
        .cu_enable_out            (cu_enable_out),
        .communication_enable_out (communication_enable_out)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] exp_ins;
        logic        exp_cu;
        logic        exp_comm;
        logic [18:0] exp_sig;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [18:0] sig(input logic [2:0] cls, input logic [5:0] op,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {cls, op, rs, rt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_bubble(input string name, input logic exp_pc_choice, input logic [18:0] exp_sig);
        check({name, ".ins_out"},   ins_out, 32'h0);
        check({name, ".cu"},        {31'b0, cu_enable_out}, 32'h0);
        check({name, ".comm"},      {31'b0, communication_enable_out}, 32'h0);
        check({name, ".pc_choice"}, {31'b0, pc_choice_out}, {31'b0, exp_pc_choice});
        check({name, ".pc_out"},    pc_out, exp_pc_choice ? pc_in_1 : pc_in_0);
        check({name, ".signal"},    {13'b0, signal_out}, {13'b0, exp_sig});
    endtask

    task automatic check_reset_state(input string name);
        check({name, ".ins_out"},   ins_out, 32'h0);
        check({name, ".signal"},    {13'b0, signal_out}, 32'h0);
        check({name, ".pc_choice"}, {31'b0, pc_choice_out}, 32'h1);
        check({name, ".cu"},        {31'b0, cu_enable_out}, 32'h0);
        check({name, ".comm"},      {31'b0, communication_enable_out}, 32'h0);
        check({name, ".pc_out"},    pc_out, pc_in_1);
    endtask

    task automatic check_issue(input string name, input logic [31:0] e_ins, input logic e_cu,
                               input logic e_comm, input logic [18:0] e_sig);
        check({name, ".ins_out"},   ins_out, e_ins);
        check({name, ".cu"},        {31'b0, cu_enable_out}, {31'b0, e_cu});
        check({name, ".comm"},      {31'b0, communication_enable_out}, {31'b0, e_comm});
        check({name, ".signal"},    {13'b0, signal_out}, {13'b0, e_sig});
        check({name, ".pc_choice"}, {31'b0, pc_choice_out}, 32'h0);
    endtask

    logic [18:0] br_sig;
    logic [18:0] jmp_sig;
    logic [18:0] halt_sig;

    initial begin
        vecs[0] = '{32'h2022_0005, 32'h2022_0005, 1'b1, 1'b0, sig(3'b000, 6'h08, 5'd1, 5'd2)};
        vecs[1] = '{32'h3C22_0005, 32'h3C22_0005, 1'b1, 1'b0, sig(3'b000, 6'h0F, 5'd1, 5'd2)};
        vecs[2] = '{32'hF8A6_0000, 32'h0,         1'b0, 1'b0, sig(3'b111, 6'h3E, 5'd5, 5'd6)};
        vecs[3] = '{32'h1C00_0000, 32'h0,         1'b0, 1'b0, sig(3'b111, 6'h07, 5'd0, 5'd0)};
        vecs[4] = '{32'h4000_0000, 32'h0,         1'b0, 1'b0, sig(3'b111, 6'h10, 5'd0, 5'd0)};
        vecs[5] = '{32'h8C43_0004, 32'h8C43_0004, 1'b1, 1'b1, sig(3'b001, 6'h23, 5'd2, 5'd3)};
        vecs[6] = '{32'h0400_0000, 32'h0,         1'b0, 1'b0, sig(3'b111, 6'h01, 5'd0, 5'd0)};
        vecs[7] = '{32'hAC43_0004, 32'hAC43_0004, 1'b1, 1'b1, sig(3'b010, 6'h2B, 5'd2, 5'd3)};
        vecs[8] = '{32'h0022_1000, 32'h0022_1000, 1'b1, 1'b0, sig(3'b000, 6'h00, 5'd1, 5'd2)};
        vecs[9] = '{32'h8C43_0004, 32'h8C43_0004, 1'b1, 1'b1, sig(3'b001, 6'h23, 5'd2, 5'd3)};
        br_sig   = sig(3'b011, 6'h04, 5'd4, 5'd5);
        jmp_sig  = sig(3'b100, 6'h02, 5'd0, 5'd0);
        halt_sig = sig(3'b101, 6'h3F, 5'd0, 5'd0);

        // Reset and START
        reset = 1'b1;
        wait_for_next_in = 1'b0;
        ins_in  = I_ALU;
        pc_in_0 = 32'h0000_0104;
        pc_in_1 = 32'h0000_0400;
        repeat (2) step();
        check_reset_state("reset");
        reset = 1'b0;
        #1;
        check({"start", ".pc_choice"}, {31'b0, pc_choice_out}, 32'h1);
        check({"start", ".pc_out"}, pc_out, 32'h0000_0400);
        step();  // START edge: ALU discarded
        check_bubble("start_discard", 1'b0, 19'h0);
        step();
        check_issue("first_alu", I_ALU, 1'b1, 1'b0, sig(3'b000, 6'h00, 5'd1, 5'd2));
        check("first_alu.pc_out", pc_out, 32'h0000_0104);

        // Table-driven RUN vectors (no stalls expected)
        for (int i = 0; i < 10; i++) begin
            ins_in  = vecs[i].ins;
            pc_in_0 = $urandom_range(32'h1000, 32'h1FFF);
            step();
            check_issue($sformatf("vec%0d", i), vecs[i].exp_ins, vecs[i].exp_cu,
                        vecs[i].exp_comm, vecs[i].exp_sig);
            check($sformatf("vec%0d.pc_out", i), pc_out, pc_in_0);
        end

        // Branch arriving while frozen: outputs hold the last LOAD
        wait_for_next_in = 1'b1;
        ins_in = I_BRANCH;
        repeat (2) begin
            step();
            check_issue("frozen_run", vecs[9].exp_ins, 1'b1, 1'b1, vecs[9].exp_sig);
        end
        wait_for_next_in = 1'b0;
        step();
        check_issue("branch_issue", I_BRANCH, 1'b1, 1'b1, br_sig);

        // Four stall cycles, then redirect, then target accepted
        ins_in = I_LOAD;  // must be discarded throughout
        for (int i = 1; i <= 3; i++) begin
            step();
            check_bubble($sformatf("br_stall%0d", i), 1'b0, br_sig);
        end
        step();
        check_bubble("br_redirect", 1'b1, br_sig);
        step();
        check_bubble("br_redirect_exit", 1'b0, br_sig);
        ins_in = I_ADDI;
        step();
        check_issue("br_target", I_ADDI, 1'b1, 1'b0, sig(3'b000, 6'h08, 5'd1, 5'd2));

        // Jump with a 3-cycle freeze in the middle of the stall
        ins_in = I_JUMP;
        step();
        check_issue("jump_issue", I_JUMP, 1'b1, 1'b1, jmp_sig);
        ins_in = I_LOAD;
        for (int i = 1; i <= 2; i++) begin
            step();
            check_bubble($sformatf("j_stall%0d", i), 1'b0, jmp_sig);
        end
        wait_for_next_in = 1'b1;
        ins_in = I_ALU;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bubble($sformatf("j_frozen%0d", i), 1'b0, jmp_sig);
        end
        wait_for_next_in = 1'b0;
        ins_in = I_LOAD;
        step();
        check_bubble("j_stall3", 1'b0, jmp_sig);
        step();
        check_bubble("j_redirect", 1'b1, jmp_sig);
        step();
        check_bubble("j_redirect_exit", 1'b0, jmp_sig);

        // HALT issued once, then permanent bubbles
        ins_in = I_HALT;
        step();
        check_issue("halt_issue", I_HALT, 1'b1, 1'b0, halt_sig);
        ins_in = I_ALU;
        for (int i = 0; i < 4; i++) begin
            step();
            check_bubble($sformatf("halted%0d", i), 1'b0, halt_sig);
        end

        // Asynchronous reset mid-HALTED, checked before any clock edge
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        reset = 1'b0;
        step();
        check_bubble("restart_discard", 1'b0, 19'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
